fir_mac_seq: RTL

Parametrised single-MAC sequential FIR filter in the core clock domain (clk2). It accepts one signed sample per valid/ready handshake and stores it in a circular history buffer. It then runs TAPS multiply-accumulate cycles against a runtime-loadable coefficient bank and presents a rounded, saturated result on a valid/ready output handshake. It is the generalised successor to the fixed 64-tap/16-bit filter: configurable width and depth, output backpressure, a coefficient load port, rounding and saturation.

---
 rtl/fir_mac_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fir_mac_seq.sv
// Single-MAC sequential FIR filter.
// Each accepted sample goes into a circular history buffer. The filter then
// walks the taps one per clock, summing coef[k] * history[newest - k]. The
// sum is rounded, shifted down by SHIFT and saturated to DATA_W bits, then
// held on a valid/ready output port until it is taken. Coefficients can be
// loaded at runtime, but only while the filter is idle.
module fir_mac_seq #(
  parameter  int DATA_W = 16,
  parameter  int COEF_W = 16,
  parameter  int TAPS   = 64,
  parameter  int SHIFT  = 15,
  parameter  int ACC_W  = 40,
  localparam int AW     = $clog2(TAPS)
) (
  input  logic              clk2,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int RS     = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [AW-1:0]            K_LAST  = AW'(TAPS - 1);
  localparam logic [ACC_W-1:0]         ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0]  ROUND_K = (SHIFT > 0) ? (ACC_ONE << RS) : '0;
  localparam logic signed [ACC_W-1:0]  SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [1:0]               state;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_idx;
  logic [AW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;

  logic signed [DATA_W-1:0] hist [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        sat_val;

  logic                     accept;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = (state == IDLE) && in_valid;

  assign prod     = coef[k] * hist[rd_idx];
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign sum      = acc + prod_ext;

  // Round half-up, shift out the coefficient fraction bits, then clamp to the output range.
  always_comb begin
    rounded = sum + ROUND_K;
    shifted = rounded >>> SHIFT;
    sat_val = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
    end
  end

  // Coefficient bank: writable only while idle; writes during a computation are dropped.
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else if (coef_we && (state == IDLE) && (int'(coef_addr) < TAPS)) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // History buffer: the accepted sample lands at the write pointer.
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
    end else if (accept) begin
      hist[wr_ptr] <= in_data;
    end
  end

  // Control: accept a sample, walk the taps newest-first, then hold the result until taken.
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_idx    <= '0;
      k         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rd_idx <= wr_ptr;
            wr_ptr <= (wr_ptr == K_LAST) ? '0 : wr_ptr + 1'b1;
            acc    <= '0;
            k      <= '0;
            state  <= MAC;
          end
        end
        MAC: begin
          if (k == K_LAST) begin
            out_data  <= sat_val;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            acc    <= sum;
            k      <= k + 1'b1;
            rd_idx <= (rd_idx == '0) ? K_LAST : rd_idx - 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
